turn_input_cond: RTL
====================

TURN_INPUT_COND -- requirements
Module: turn_input_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive synchronized samples that must disagree with the filtered value before it flips; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; forces all state to the reset values of REQ-020 while low.
REQ-004 raw_left  input  1  left turn-stalk contact, asynchronous to clk, may bounce.
REQ-005 raw_right  input  1  right turn-stalk contact, asynchronous to clk, may bounce.
REQ-006 raw_hazard  input  1  hazard push-button, asynchronous to clk, may bounce.
REQ-007 left  output  1  registered left-turn request, feeds the tail-light sequencer left input.
REQ-008 right  output  1  registered right-turn request, feeds the tail-light sequencer right input.
REQ-009 hazard_on  output  1  registered hazard-latch state.

Function
REQ-010 Each raw input SHALL pass through its own two-flop synchronizer (s1, s2) before any other logic.
REQ-011 Each channel SHALL hold a filtered bit and a mismatch counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-012 The counter SHALL increment on each edge where s2 != filtered, saturating at DEBOUNCE_CYCLES.
REQ-013 The counter SHALL clear to 0 on any edge where s2 == filtered; a glitch shorter than DEBOUNCE_CYCLES samples at s2 SHALL NOT change filtered.
REQ-014 On the edge where the counter would reach DEBOUNCE_CYCLES, filtered SHALL take the value of s2 and the counter SHALL clear.
REQ-015 hazard_on SHALL toggle on the edge after filtered hazard goes 0->1; a filtered 1->0 SHALL NOT affect it. Holding the button SHALL toggle exactly once.
REQ-016 Next output values: left = hazard_on | (f_left & ~f_right); right = hazard_on | (f_right & ~f_left). Registered, updating one edge after the terms change.
REQ-017 Both filtered stalk inputs high with hazard_on low (illegal stalk position) SHALL drive left = right = 0.
REQ-018 Latency, raw_left/raw_right clean step held stable: output changes on rising edge DEBOUNCE_CYCLES+3 after the first edge that samples the new level (7 for default).
REQ-019 Latency, raw_hazard clean press: hazard_on toggles on edge DEBOUNCE_CYCLES+3 and left/right follow on edge DEBOUNCE_CYCLES+4.

Reset
REQ-020 While reset is low: s1, s2, filtered bits, counters, hazard_on, left and right SHALL all be 0, asynchronously, with no dependence on clk.
REQ-021 reset asserted mid-operation SHALL clear the hazard latch and any partial debounce count. After release, inputs already held high SHALL re-qualify with the full latency of REQ-018/REQ-019.
REQ-022 Release of reset is synchronous to the system; the first state update SHALL occur on the first rising edge of clk with reset high.

Verification (DEBOUNCE_CYCLES=4)
REQ-023 raw_left 0->1 held -> left=1 from edge 7 onward; right=0 and hazard_on=0 throughout.
REQ-024 raw_right pulses high for 3 cycles, then low -> right stays 0 for 20 cycles.
REQ-025 raw_right bounces 1,0,1,0 each cycle, then is held 1 -> right=1 exactly 7 edges after the last 0->1 transition.
REQ-026 raw_hazard pressed and held for 10 cycles, then released -> hazard_on=1 at edge 7, left=right=1 at edge 8, no further toggle. A second press -> hazard_on=0 and left=right=0, unless a stalk is held.
REQ-027 raw_left and raw_right both held high -> left=right=0. Press hazard -> left=right=1. Release hazard via second press -> left=right=0 again.
REQ-028 Hazard active with raw_left held, then reset pulsed low for 2 cycles mid-cycle -> all outputs 0 immediately; after release, left=1 at edge 7 and hazard_on remains 0.

Source files
------------

// File: rtl/turn_input_cond.sv
// Turn-stalk and hazard-button input conditioner: per-channel synchronizer and
// debounce filter, a toggle latch for the hazard button, and registered turn requests.
module turn_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_left,
  input  logic raw_right,
  input  logic raw_hazard,
  output logic left,
  output logic right,
  output logic hazard_on
);

  localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NCH      = 3;
  localparam int unsigned CH_LEFT  = 0;
  localparam int unsigned CH_RIGHT = 1;
  localparam int unsigned CH_HAZ   = 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] filt;
  logic [CW-1:0]  cnt [NCH];
  logic           filt_hazard_d;
  logic           next_left;
  logic           next_right;

  assign raw = {raw_hazard, raw_right, raw_left};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Flipping on the edge the count would reach DEBOUNCE_CYCLES means the
  // counter never actually holds that value; saturation is implicit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= CNT_LAST) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_hazard_d <= 1'b0;
      hazard_on     <= 1'b0;
    end else begin
      filt_hazard_d <= filt[CH_HAZ];
      if (filt[CH_HAZ] && !filt_hazard_d) begin
        hazard_on <= ~hazard_on;
      end
    end
  end

  // Both stalks active is an illegal position and yields no turn request.
  always_comb begin
    next_left  = hazard_on | (filt[CH_LEFT] & ~filt[CH_RIGHT]);
    next_right = hazard_on | (filt[CH_RIGHT] & ~filt[CH_LEFT]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left  <= 1'b0;
      right <= 1'b0;
    end else begin
      left  <= next_left;
      right <= next_right;
    end
  end

endmodule
